rx_byte_fifo: RTL and testbench

Byte FIFO between the UART receiver and the downstream character consumers (blackbox/LCD path). It captures every `rx_data_valid` pulse from the receiver, so bytes are not lost while the consumer is busy, and presents them on a valid/ready interface. It drops bytes on overflow and records the event in a sticky flag. The receiver side cannot be back-pressured: its ready is tied high in the top level.

---
 rtl/rx_byte_fifo.sv | 120 ++++++++++++
 tb/tb_rx_byte_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_fifo.sv
// Byte FIFO between the UART receiver and the character consumers: show-ahead read, sticky overflow flag.
// Optional macro RX_FIFO_CRLF_FILTER_EN drops 0x0D/0x0A write strobes before they reach storage.
module rx_byte_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    CLK_I,
  input  logic                    RST_N_I,
  input  logic                    CLR_I,
  input  logic [PAYLOAD_BITS-1:0] WR_DATA_I,
  input  logic                    WR_VALID_I,
  output logic [PAYLOAD_BITS-1:0] RD_DATA_O,
  output logic                    RD_VALID_O,
  input  logic                    RD_READY_I,
  output logic [DEPTH_LOG2:0]     LEVEL_O,
  output logic                    FULL_O,
  output logic                    EMPTY_O,
  output logic                    OVF_O,
  output logic [1:0]              STATE_O
);

  // Handshake: a byte leaves on every rising edge where RD_VALID_O && RD_READY_I;
  // RD_DATA_O is stable while RD_VALID_O is high and no pop occurs. The write side
  // has no ready: WR_VALID_I is a one-cycle strobe that is stored, filtered or dropped.

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] LVL_LAST = LW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_LOG2:0]     wr_ptr;
  logic [DEPTH_LOG2:0]     rd_ptr;
  logic [DEPTH_LOG2:0]     level;
  logic                    ovf_q;
  logic                    empty;
  logic                    full;
  logic                    wr_ok;
  logic                    push;
  logic                    pop;
  logic                    ovf_evt;
  state_t                  state_q;
  state_t                  state_d;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  // Modular difference of the extended pointers yields 0..DEPTH without ambiguity.
  assign level = wr_ptr - rd_ptr;

`ifdef RX_FIFO_CRLF_FILTER_EN
  assign wr_ok = WR_VALID_I &&
                 (WR_DATA_I != PAYLOAD_BITS'(8'h0D)) &&
                 (WR_DATA_I != PAYLOAD_BITS'(8'h0A));
`else
  assign wr_ok = WR_VALID_I;
`endif

  assign pop     = !empty && RD_READY_I;
  assign push    = wr_ok && (!full || pop);
  assign ovf_evt = wr_ok && full && !pop;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else if (CLR_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (ovf_evt) ovf_q  <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; only the pointers define what is valid.
  always_ff @(posedge CLK_I) begin
    if (push && !CLR_I) mem[wr_ptr[DEPTH_LOG2-1:0]] <= WR_DATA_I;
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (CLR_I) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY:   if (push) state_d = ST_PARTIAL;
        ST_PARTIAL: begin
          if (push && !pop && level == LVL_LAST)   state_d = ST_FULL;
          else if (pop && !push && level == PTR_ONE) state_d = ST_EMPTY;
        end
        ST_FULL:    if (pop && !push) state_d = ST_PARTIAL;
        default:    state_d = ST_EMPTY;
      endcase
    end
  end

  assign RD_DATA_O  = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign RD_VALID_O = !empty;
  assign LEVEL_O    = level;
  assign FULL_O     = full;
  assign EMPTY_O    = empty;
  assign OVF_O      = ovf_q;
  assign STATE_O    = state_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo (default DEPTH_LOG2=4): queue scoreboard plus per-scenario tasks.
module tb_rx_byte_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       ovf;
  logic [1:0] state;

  logic [7:0] exp_q[$];
  logic       ovf_m;
  logic [7:0] last_pop;
  int         checks;
  int         errors;

  rx_byte_fifo #(.DEPTH_LOG2(4), .PAYLOAD_BITS(8)) dut (
    .CLK_I      (clk),
    .RST_N_I    (rst_n),
    .CLR_I      (clr),
    .WR_DATA_I  (wr_data),
    .WR_VALID_I (wr_valid),
    .RD_DATA_O  (rd_data),
    .RD_VALID_O (rd_valid),
    .RD_READY_I (rd_ready),
    .LEVEL_O    (level),
    .FULL_O     (full),
    .EMPTY_O    (empty),
    .OVF_O      (ovf),
    .STATE_O    (state)
  );

  always #5 clk = ~clk;

  function automatic bit is_crlf(input logic [7:0] d);
`ifdef RX_FIFO_CRLF_FILTER_EN
    return (d == 8'h0D) || (d == 8'h0A);
`else
    return 1'b0;
`endif
  endfunction

  // Driver: applies one cycle of inputs, pops/compares the scoreboard on a handshake,
  // updates the reference queue, then advances to just after the next rising edge.
  task automatic drive_cycle(input logic wv, input logic [7:0] wd, input logic rdy, input logic c);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rdy;
    clr      = c;
    #1;
    if (!c && rdy && exp_q.size() > 0) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
        errors++;
        $display("FAIL pop_data got valid=%0b data=%02h exp valid=1 data=%02h", rd_valid, rd_data, exp_q[0]);
      end
      last_pop = exp_q.pop_front();
    end
    if (c) begin
      exp_q.delete();
      ovf_m = 1'b0;
    end else if (wv && !is_crlf(wd)) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(wd);
      else                      ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0 || rd_valid !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset got lvl=%0d e=%0b f=%0b o=%0b v=%0b st=%0d exp 0 1 0 0 0 0", level, empty, full, ovf, rd_valid, state);
    end
    rst_n = 1'b1;
    exp_q.delete();
    ovf_m = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] b [4];
    b = '{8'h45, 8'h67, 8'h6F, 8'h72};
    drive_cycle(1'b1, b[0], 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h45) begin
      errors++;
      $display("FAIL write_latency got valid=%0b data=%02h exp valid=1 data=45", rd_valid, rd_data);
    end
    for (int i = 1; i < 4; i++) drive_cycle(1'b1, b[i], 1'b0, 1'b0);
    checks++;
    if (level !== 5'd4 || rd_data !== 8'h45 || state !== 2'd1) begin
      errors++;
      $display("FAIL basic_fill got lvl=%0d data=%02h st=%0d exp 4 45 1", level, rd_data, state);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1 || rd_valid !== 1'b0 || last_pop !== 8'h72 || state !== 2'd0) begin
      errors++;
      $display("FAIL basic_drain got e=%0b v=%0b last=%02h st=%0d exp 1 0 72 0", empty, rd_valid, last_pop, state);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || ovf !== 1'b0 || level !== 5'd16 || state !== 2'd2) begin
      errors++;
      $display("FAIL ovf_full got f=%0b o=%0b lvl=%0d st=%0d exp 1 0 16 2", full, ovf, level, state);
    end
    drive_cycle(1'b1, 8'h10, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || ovf !== ovf_m || level !== 5'd16 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL ovf_set got f=%0b o=%0b lvl=%0d data=%02h exp 1 %0b 16 00", full, ovf, level, rd_data, ovf_m);
    end
    for (int i = 0; i < 16; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1 || ovf !== 1'b1 || last_pop !== 8'h0F) begin
      errors++;
      $display("FAIL ovf_drain got e=%0b o=%0b last=%02h exp 1 1 0f", empty, ovf, last_pop);
    end
  endtask

  task automatic test_full_push_pop();
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd16 || ovf !== 1'b0 || full !== 1'b1 || rd_data !== 8'h31) begin
      errors++;
      $display("FAIL full_pushpop got lvl=%0d o=%0b f=%0b data=%02h exp 16 0 1 31", level, ovf, full, rd_data);
    end
    for (int i = 0; i < 16; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (last_pop !== 8'hAA || empty !== 1'b1) begin
      errors++;
      $display("FAIL full_last got last=%02h e=%0b exp aa 1", last_pop, empty);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'($urandom_range(8'h20, 8'h7E)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 8'($urandom_range(8'h20, 8'h7E)), 1'b1, 1'b0);
      if (level !== 5'd3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_level got %0d cycles off level exp 0 (last lvl=%0d exp 3)", bad, level);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got e=%0b exp 1", empty);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL underflow got lvl=%0d e=%0b f=%0b v=%0b exp 0 1 0 0", level, empty, full, rd_valid);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 17; i++) drive_cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd5 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre got lvl=%0d o=%0b exp 5 1", level, ovf);
    end
    drive_cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    checks++;
    if (level !== 5'd0 || ovf !== 1'b0 || rd_valid !== 1'b0 || empty !== 1'b1 || state !== 2'd0) begin
      errors++;
      $display("FAIL clr got lvl=%0d o=%0b v=%0b e=%0b st=%0d exp 0 0 0 1 0", level, ovf, rd_valid, empty, state);
    end
  endtask

  task automatic test_crlf();
    logic [7:0] s [6];
    logic [4:0] exp_lvl;
    s = '{8'h45, 8'h67, 8'h6F, 8'h72, 8'h0D, 8'h0A};
`ifdef RX_FIFO_CRLF_FILTER_EN
    exp_lvl = 5'd4;
`else
    exp_lvl = 5'd6;
`endif
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, s[i], 1'b0, 1'b0);
    checks++;
    if (level !== exp_lvl || ovf !== 1'b0) begin
      errors++;
      $display("FAIL crlf_level got lvl=%0d o=%0b exp %0d 0", level, ovf, exp_lvl);
    end
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL crlf_drain got e=%0b exp 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got lvl=%0d v=%0b e=%0b exp 0 0 1", level, rd_valid, empty);
    end
    exp_q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1 || last_pop !== 8'h5A) begin
      errors++;
      $display("FAIL reset_resume got e=%0b last=%02h exp 1 5a", empty, last_pop);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ovf_m    = 1'b0;
    last_pop = 8'h00;
    rst_n    = 1'b0;
    clr      = 1'b0;
    wr_data  = 8'h00;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_underflow();
    test_clear();
    test_crlf();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
